// File: rtl/bcd_stopwatch_counter_if.sv
// Control and reading bundle between the button/debounce logic and the stopwatch counter.
// The master side drives the controls; the slave side returns the readings and status.
interface bcd_stopwatch_counter_if #(
    parameter int NUM_DIGITS = 2
);
    localparam int W = 4 * NUM_DIGITS;

    logic         count_enabled;
    logic         count_down;
    logic         load;
    logic [W-1:0] load_value;
    logic         lap;
    logic [W-1:0] time_reading;
    logic [W-1:0] lap_reading;
    logic         lap_valid;
    logic         tick;
    logic         wrap;
    logic         zero;

    modport master (
        output count_enabled, count_down, load, load_value, lap,
        input  time_reading, lap_reading, lap_valid, tick, wrap, zero
    );

    modport slave (
        input  count_enabled, count_down, load, load_value, lap,
        output time_reading, lap_reading, lap_valid, tick, wrap, zero
    );
endinterface

// File: rtl/bcd_stopwatch_counter.sv
// Parametrised BCD stopwatch: prescaled up/down digit counter with preset load and lap capture.
// Digits can only ever hold 0-9; load values above 9 are clamped on the way in.
module bcd_stopwatch_counter #(
    parameter int CLK_FREQ      = 100000000,
    parameter int TICK_HZ       = 1,
    parameter int NUM_DIGITS    = 2,
    parameter bit DOWN_SATURATE = 1'b1
) (
    input  logic                     clk,
    input  logic                     init_regs,
    bcd_stopwatch_counter_if.slave   bus
);
    localparam int              DIV      = CLK_FREQ / TICK_HZ;
    localparam int              PW       = $clog2(DIV);
    localparam int              W        = 4 * NUM_DIGITS;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] prescaler;
    logic [W-1:0]  digits;
    logic [W-1:0]  lap_q;
    logic          lap_valid_q;
    logic          tick_q;
    logic          wrap_q;

    logic [W-1:0]  up_value;
    logic [W-1:0]  down_value;
    logic [W-1:0]  load_clamped;
    logic [W-1:0]  step_value;
    logic          carry;
    logic          borrow;
    logic          step_wrap;
    logic          step_now;

    // Ripple the carry/borrow digit by digit; a surviving carry means all-9s, a surviving borrow all-0s.
    always_comb begin
        up_value     = '0;
        down_value   = '0;
        load_clamped = '0;
        carry        = 1'b1;
        borrow       = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (carry) begin
                if (digits[4*k +: 4] == 4'd9) begin
                    up_value[4*k +: 4] = 4'd0;
                end else begin
                    up_value[4*k +: 4] = digits[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                up_value[4*k +: 4] = digits[4*k +: 4];
            end

            if (borrow) begin
                if (digits[4*k +: 4] == 4'd0) begin
                    down_value[4*k +: 4] = 4'd9;
                end else begin
                    down_value[4*k +: 4] = digits[4*k +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end else begin
                down_value[4*k +: 4] = digits[4*k +: 4];
            end

            load_clamped[4*k +: 4] = (bus.load_value[4*k +: 4] > 4'd9) ? 4'd9 : bus.load_value[4*k +: 4];
        end
    end

    always_comb begin
        step_value = up_value;
        step_wrap  = carry;
        if (bus.count_down) begin
            if (borrow && DOWN_SATURATE) begin
                step_value = '0;
                step_wrap  = 1'b0;
            end else begin
                step_value = down_value;
                step_wrap  = borrow;
            end
        end
    end

    assign step_now = bus.count_enabled && (prescaler == PRE_LAST);

    always_ff @(posedge clk) begin
        if (init_regs) begin
            prescaler   <= '0;
            digits      <= '0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            // Lap samples the register value, so it sees the reading from before any load/step this edge.
            if (bus.lap) begin
                lap_q       <= digits;
                lap_valid_q <= 1'b1;
            end
            if (bus.load) begin
                digits    <= load_clamped;
                prescaler <= '0;
            end else if (step_now) begin
                prescaler <= '0;
                digits    <= step_value;
                tick_q    <= 1'b1;
                wrap_q    <= step_wrap;
            end else if (bus.count_enabled) begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    assign bus.time_reading = digits;
    assign bus.lap_reading  = lap_q;
    assign bus.lap_valid    = lap_valid_q;
    assign bus.tick         = tick_q;
    assign bus.wrap         = wrap_q;
    assign bus.zero         = (digits == '0);
endmodule
